// File: rtl/led_panel_pkg.sv
// led_panel_pkg: op/state encodings and frame-buffer size defaults shared by the write arbiter.
package led_panel_pkg;
  localparam int NUM_COLS_DEF = 16;
  localparam int COL_W_DEF = 8;
  typedef enum logic [1:0] {OP_SET = 2'b00, OP_CLR = 2'b01, OP_FILL = 2'b10, OP_CLEAR_ALL = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
endpackage

// File: rtl/fb_write_arbiter_if.sv
// fb_write_arbiter_if: two requester command channels plus the masked frame-buffer write port.
// frame_hold exists only when FB_ARB_HOLD_EN is defined.
interface fb_write_arbiter_if #(parameter int COL_W = led_panel_pkg::COL_W_DEF);
  logic r0_valid, r0_ready, r1_valid, r1_ready;
  logic [1:0] r0_op, r1_op;
  logic [3:0] r0_col, r1_col;
  logic [2:0] r0_row, r1_row;
  logic fb_we;
  logic [3:0] fb_col;
  logic [COL_W-1:0] fb_wdata, fb_wmask;
  logic grant_id, busy;
`ifdef FB_ARB_HOLD_EN
  logic frame_hold;
  modport slave (input r0_valid, r0_op, r0_col, r0_row, r1_valid, r1_op, r1_col, r1_row, frame_hold,
                 output r0_ready, r1_ready, fb_we, fb_col, fb_wdata, fb_wmask, grant_id, busy);
  modport master (output r0_valid, r0_op, r0_col, r0_row, r1_valid, r1_op, r1_col, r1_row, frame_hold,
                  input r0_ready, r1_ready, fb_we, fb_col, fb_wdata, fb_wmask, grant_id, busy);
`else
  modport slave (input r0_valid, r0_op, r0_col, r0_row, r1_valid, r1_op, r1_col, r1_row,
                 output r0_ready, r1_ready, fb_we, fb_col, fb_wdata, fb_wmask, grant_id, busy);
  modport master (output r0_valid, r0_op, r0_col, r0_row, r1_valid, r1_op, r1_col, r1_row,
                  input r0_ready, r1_ready, fb_we, fb_col, fb_wdata, fb_wmask, grant_id, busy);
`endif
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  assign grant[0] = valid[0] && (!valid[1] || last_grant);
  assign grant[1] = valid[1] && (!valid[0] || !last_grant);
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: arbitrates two pixel-command requesters onto one masked frame-buffer write port.
// Optional FB_ARB_HOLD_EN adds frame_hold, which blocks new commands while in IDLE.
module fb_write_arbiter
  import led_panel_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEF,
  parameter int COL_W = COL_W_DEF
) (
  input logic clk,
  input logic reset_n,
  fb_write_arbiter_if.slave bus
);
  state_t state, state_n;
  logic last_grant, last_grant_n, hold, sel, we_n, gid_n, hs;
  logic [1:0] gnt, op;
  logic [3:0] col, col_n;
  logic [2:0] row;
  logic [COL_W-1:0] bit_m, wdata_n, wmask_n;
`ifdef FB_ARB_HOLD_EN
  assign hold = bus.frame_hold;
`else
  assign hold = 1'b0;
`endif
  rr_arb2 u_arb (.valid({bus.r1_valid, bus.r0_valid}), .last_grant(last_grant), .grant(gnt));
  assign bus.r0_ready = reset_n && state == IDLE && !hold && gnt[0];
  assign bus.r1_ready = reset_n && state == IDLE && !hold && gnt[1];
  assign hs = bus.r0_ready || bus.r1_ready;
  assign sel = gnt[1];
  assign op = sel ? bus.r1_op : bus.r0_op;
  assign col = sel ? bus.r1_col : bus.r0_col;
  assign row = sel ? bus.r1_row : bus.r0_row;
  assign bit_m = COL_W'(1) << row;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_n = IDLE;
    last_grant_n = last_grant;
    we_n = 1'b0;
    gid_n = bus.grant_id;
    col_n = bus.fb_col;
    wdata_n = bus.fb_wdata;
    wmask_n = bus.fb_wmask;
    if (state == IDLE && hs) begin
      last_grant_n = sel;
      gid_n = sel;
      we_n = 1'b1;
      state_n = op == OP_CLEAR_ALL ? CLEAR : WRITE;
      col_n = op == OP_CLEAR_ALL ? 4'd0 : col;
      wmask_n = op[1] ? '1 : bit_m;
      wdata_n = op == OP_SET ? bit_m : op == OP_FILL ? '1 : '0;
    end else if (state == CLEAR && bus.fb_col != 4'(NUM_COLS - 1)) begin
      state_n = CLEAR;
      we_n = 1'b1;
      col_n = bus.fb_col + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      bus.fb_we <= 1'b0;
      bus.fb_col <= '0;
      bus.fb_wdata <= '0;
      bus.fb_wmask <= '0;
      bus.grant_id <= 1'b0;
    end else begin
      state <= state_n;
      last_grant <= last_grant_n;
      bus.fb_we <= we_n;
      bus.fb_col <= col_n;
      bus.fb_wdata <= wdata_n;
      bus.fb_wmask <= wmask_n;
      bus.grant_id <= gid_n;
    end
  end
endmodule
